// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: oversampling UART receiver with configurable framing, error flags and valid/ready output.
module uart_rx_cfg #(
  parameter int CLOCK_FREQUENCY = 10_000_000,
  parameter int BAUD_RATE       = 115200,
  parameter int OVERSAMPLE      = 8,
  parameter int DATA_BITS       = 8,
  parameter int PARITY_MODE     = 0,
  parameter int STOP_BITS       = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_rx_serial,
  input  logic                 i_rx_ready,
  output logic                 o_rx_valid,
  output logic [DATA_BITS-1:0] o_rx_data,
  output logic                 o_parity_err,
  output logic                 o_frame_err,
  output logic                 o_break,
  output logic                 o_overrun,
  output logic                 o_busy
);
  localparam int DIV = (CLOCK_FREQUENCY + BAUD_RATE * OVERSAMPLE / 2) / (BAUD_RATE * OVERSAMPLE);
  localparam int CW  = $clog2(DIV);
  localparam int PW  = $clog2(OVERSAMPLE);
  localparam int HW  = $clog2(OVERSAMPLE + 1);
  if (DIV < 2 || OVERSAMPLE < 4 || OVERSAMPLE % 2 != 0 || DATA_BITS < 5 || DATA_BITS > 9 ||
      PARITY_MODE > 2 || STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad
    $error("uart_rx_cfg: unsupported parameter set");
  end
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;
  state_t state, state_n;
  logic s1, s2, filt, tick, samp, start_det, last_data, last_stop, stop_bad;
  logic armed, par_bit, pe, fe, s0l, done, d_fe, d_brk;
  logic [1:0] hist;
  logic [CW-1:0] tcnt;
  logic [PW-1:0] ph;
  logic [HW-1:0] hcnt;
  logic [3:0] bcnt;
  logic [DATA_BITS-1:0] sh;
  assign filt      = (s2 & hist[0]) | (s2 & hist[1]) | (hist[0] & hist[1]);
  assign tick      = tcnt == CW'(DIV - 1);
  assign samp      = tick && ph == (state == START ? PW'(OVERSAMPLE / 2 - 1) : PW'(OVERSAMPLE - 1));
  assign start_det = state == IDLE && armed && !filt;
  assign last_data = bcnt == 4'(DATA_BITS - 1);
  assign last_stop = bcnt == 4'(STOP_BITS - 1);
  assign stop_bad  = fe | !filt;
  assign o_busy    = state != IDLE;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:      if (start_det) state_n = START;
      START:     if (samp) state_n = filt ? IDLE : DATA;
      DATA:      if (samp && last_data) state_n = PARITY_MODE != 0 ? PARITY : STOP;
      PARITY:    if (samp) state_n = STOP;
      STOP:      if (samp && last_stop) state_n = stop_bad ? WAIT_HIGH : IDLE;
      WAIT_HIGH: if (armed) state_n = IDLE;
      default:   state_n = IDLE;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1           <= 1'b1;
      s2           <= 1'b1;
      hist         <= 2'b11;
      state        <= IDLE;
      tcnt         <= '0;
      ph           <= '0;
      hcnt         <= '0;
      armed        <= 1'b0;
      bcnt         <= '0;
      sh           <= '0;
      par_bit      <= 1'b0;
      pe           <= 1'b0;
      fe           <= 1'b0;
      s0l          <= 1'b0;
      done         <= 1'b0;
      d_fe         <= 1'b0;
      d_brk        <= 1'b0;
      o_rx_valid   <= 1'b0;
      o_rx_data    <= '0;
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
      o_break      <= 1'b0;
      o_overrun    <= 1'b0;
    end else begin
      s1    <= i_rx_serial;
      s2    <= s1;
      hist  <= {hist[0], s2};
      state <= state_n;
      tcnt  <= (start_det || tick) ? '0 : tcnt + 1'b1;
      if (start_det) ph <= '0;
      else if (tick) ph <= samp ? '0 : ph + 1'b1;
      // Start detection stays disarmed until the line has idled high for a full bit time
      hcnt <= (armed || !filt) ? '0 : hcnt + HW'(tick);
      if (state == STOP && samp && last_stop && stop_bad) armed <= 1'b0;
      else if (!armed && tick && filt && hcnt == HW'(OVERSAMPLE - 1)) armed <= 1'b1;
      done <= 1'b0;
      if (samp)
        case (state)
          START: begin
            bcnt <= '0;
            pe   <= 1'b0;
            fe   <= 1'b0;
          end
          DATA: begin
            sh   <= {filt, sh[DATA_BITS-1:1]};
            bcnt <= last_data ? '0 : bcnt + 1'b1;
          end
          PARITY: begin
            par_bit <= filt;
            pe      <= (PARITY_MODE == 2) ^ (^sh) ^ filt;
          end
          STOP: begin
            fe   <= stop_bad;
            bcnt <= bcnt + 1'b1;
            if (bcnt == '0) s0l <= !filt;
            if (last_stop) begin
              done  <= 1'b1;
              d_fe  <= stop_bad;
              d_brk <= sh == '0 && (PARITY_MODE == 0 || !par_bit) && (bcnt == '0 ? !filt : s0l);
            end
          end
          default: ;
        endcase
      o_overrun <= 1'b0;
      if (o_rx_valid && i_rx_ready) begin
        o_rx_valid   <= 1'b0;
        o_parity_err <= 1'b0;
        o_frame_err  <= 1'b0;
        o_break      <= 1'b0;
      end
      if (done) begin
        if (!o_rx_valid || i_rx_ready) begin
          o_rx_valid   <= 1'b1;
          o_rx_data    <= sh;
          o_parity_err <= pe;
          o_frame_err  <= d_fe;
          o_break      <= d_brk;
        end else o_overrun <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: scoreboard bench for an 8N1 receiver and an 8E2 receiver driven with serial frames.
module tb_uart_rx_cfg;
  localparam int DIV  = (10_000_000 + 115200 * 8 / 2) / (115200 * 8);
  localparam int BITC = DIV * 8;
  typedef struct packed {logic [7:0] d; logic pe, fe, brk;} word_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx0 = 1'b1, rx1 = 1'b1, rdy0 = 1'b1, rdy1 = 1'b1;
  logic v0, pe0, fe0, bk0, ov0, bs0, v1, pe1, fe1, bk1, ov1, bs1;
  logic [7:0] d0, d1;
  word_t q0[$], q1[$];
  int exp_ovr[2], ovr_cnt[2];
  int n_chk = 0, n_pass = 0;
  always #5 clk = ~clk;
  uart_rx_cfg u0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_rx_serial(rx0), .i_rx_ready(rdy0),
    .o_rx_valid(v0), .o_rx_data(d0), .o_parity_err(pe0), .o_frame_err(fe0),
    .o_break(bk0), .o_overrun(ov0), .o_busy(bs0)
  );
  uart_rx_cfg #(.PARITY_MODE(1), .STOP_BITS(2)) u1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_rx_serial(rx1), .i_rx_ready(rdy1),
    .o_rx_valid(v1), .o_rx_data(d1), .o_parity_err(pe1), .o_frame_err(fe1),
    .o_break(bk1), .o_overrun(ov1), .o_busy(bs1)
  );
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, got, want);
  endtask
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic line(input bit p, input logic v);
    if (p) rx1 = v;
    else rx0 = v;
  endtask
  // mode 0: word expected, 1: word dropped by overrun, 2: frame must be ignored
  task automatic send(input bit p, input logic [7:0] d, input bit pflip, input bit s0low,
                      input bit s1low, input int mode, input int gap);
    logic pbit;
    word_t w;
    pbit  = (^d) ^ pflip;
    w.d   = d;
    w.pe  = p && (($countones(d) + int'(pbit)) % 2 == 1);
    w.fe  = s0low || (p && s1low);
    w.brk = d == 8'h00 && (!p || !pbit) && s0low;
    if (mode == 0) begin
      if (p) q1.push_back(w);
      else q0.push_back(w);
    end else if (mode == 1) exp_ovr[p]++;
    line(p, 1'b0);
    cyc(BITC);
    for (int i = 0; i < 8; i++) begin
      line(p, d[i]);
      cyc(BITC);
    end
    if (p) begin
      line(p, pbit);
      cyc(BITC);
    end
    line(p, !s0low);
    cyc(BITC);
    if (p) begin
      line(p, !s1low);
      cyc(BITC);
    end
    line(p, 1'b1);
    cyc(gap);
  endtask
  always @(negedge clk) begin
    if (ov0) ovr_cnt[0]++;
    if (v0 && rdy0) begin
      if (q0.size() == 0) check("u0 unexpected word", q0.size(), 1);
      else check("u0 word", {d0, pe0, fe0, bk0}, q0.pop_front());
    end
  end
  always @(negedge clk) begin
    if (ov1) ovr_cnt[1]++;
    if (v1 && rdy1) begin
      if (q1.size() == 0) check("u1 unexpected word", q1.size(), 1);
      else check("u1 word", {d1, pe1, fe1, bk1}, q1.pop_front());
    end
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    word_t w;
    bit s1l;
    cyc(5);
    check("reset valid", v0, 0);
    check("reset data", d0, 0);
    check("reset parity_err", pe0, 0);
    check("reset frame_err", fe0, 0);
    check("reset break", bk0, 0);
    check("reset overrun", ov0, 0);
    check("reset busy", bs0, 0);
    check("reset u1 valid", v1, 0);
    rst_n = 1'b1;
    cyc(200);
    send(0, 8'hA5, 0, 0, 0, 0, 20);
    check("busy after frame", bs0, 0);
    send(1, 8'h03, 1, 0, 0, 0, 20);
    send(1, 8'h03, 0, 0, 0, 0, 20);
    send(0, 8'h55, 0, 1, 0, 0, 30);
    send(0, 8'h00, 0, 0, 0, 2, 200);
    send(0, 8'hC3, 0, 0, 0, 0, 20);
    w = '{d: 8'h00, pe: 1'b0, fe: 1'b1, brk: 1'b1};
    q0.push_back(w);
    rx0 = 1'b0;
    cyc(3 * 10 * BITC);
    rx0 = 1'b1;
    cyc(300);
    rdy0 = 1'b0;
    send(0, 8'h11, 0, 0, 0, 0, 20);
    send(0, 8'h22, 0, 0, 0, 1, 20);
    check("overrun holds valid", v0, 1);
    check("overrun holds data", d0, 8'h11);
    rdy0 = 1'b1;
    cyc(2);
    check("valid drops after accept", v0, 0);
    rx0 = 1'b0;
    cyc(2 * DIV);
    rx0 = 1'b1;
    cyc(2 * BITC);
    check("glitch leaves idle", bs0, 0);
    rx0 = 1'b0;
    cyc(3 * BITC);
    rst_n = 1'b0;
    cyc(2);
    check("mid-frame reset valid", v0, 0);
    check("mid-frame reset busy", bs0, 0);
    rst_n = 1'b1;
    rx0 = 1'b1;
    cyc(200);
    send(0, 8'h3C, 0, 0, 0, 0, 20);
    for (int i = 0; i < 16; i++) send(0, 8'($urandom), 0, 0, 0, 0, $urandom_range(0, 40));
    for (int i = 0; i < 16; i++) begin
      s1l = $urandom_range(0, 3) == 0;
      send(1, 8'($urandom), 1'($urandom_range(0, 1)), 0, s1l, 0, s1l ? 150 : $urandom_range(0, 40));
    end
    for (int i = 0; i < 2000 && (q0.size() != 0 || q1.size() != 0); i++) cyc(1);
    check("u0 scoreboard drained", q0.size(), 0);
    check("u1 scoreboard drained", q1.size(), 0);
    check("u0 overrun cycles", ovr_cnt[0], exp_ovr[0]);
    check("u1 overrun cycles", ovr_cnt[1], exp_ovr[1]);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
